// File: rtl/mceliece_params_pkg.sv
// mceliece_params_pkg
// Shared Classic McEliece parameters and helpers for the decapsulation input
// path: n/m/t per parameter set, 32-bit word-count rounding, the source memory
// section enum, and the base offset of each section in the source memory.
package mceliece_params_pkg;

  // Source memory sections, in the order they are streamed into decap.
  typedef enum logic [1:0] {
    SEC_S  = 2'd0,
    SEC_C1 = 2'd1,
    SEC_C0 = 2'd2,
    SEC_PG = 2'd3
  } section_e;

  // Loader sequencer states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    HOLD = 3'd3,
    FIN  = 3'd4
  } ld_state_e;

  function automatic int set_n(input int ps);
    case (ps)
      1:       return 3488;
      2:       return 4608;
      3:       return 6688;
      5:       return 8192;
      default: return 6960;
    endcase
  endfunction

  function automatic int set_m(input int ps);
    return (ps == 1) ? 12 : 13;
  endfunction

  function automatic int set_t(input int ps);
    case (ps)
      1:       return 64;
      2:       return 96;
      3:       return 128;
      5:       return 128;
      default: return 119;
    endcase
  endfunction

  // Number of 32-bit words needed to hold 'bits' bits.
  function automatic int words32(input int bits);
    return (bits + 31) / 32;
  endfunction

  // Word offset of a section inside the contiguous source memory image.
  function automatic int section_base(input section_e sec, input int s_words,
                                      input int c1_words, input int c0_words);
    case (sec)
      SEC_C1:  return s_words;
      SEC_C0:  return s_words + c1_words;
      SEC_PG:  return s_words + c1_words + c0_words;
      default: return 0;
    endcase
  endfunction

  // Section that follows 'sec'; SEC_PG wraps back to SEC_S so the loader is
  // ready for the next run without an extra initialisation step.
  function automatic section_e next_section(input section_e sec);
    case (sec)
      SEC_S:   return SEC_C1;
      SEC_C1:  return SEC_C0;
      SEC_C0:  return SEC_PG;
      default: return SEC_S;
    endcase
  endfunction

endpackage

// File: rtl/loader_section_ctr.sv
// loader_section_ctr
// Word index counter for one source section. The last-word index is latched
// on every load, so a single instance serves all sections in turn.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   load       clear idx and latch load_last as the new last-word index
//   load_last  last valid index of the section being entered
//   adv        advance idx by one (ignored when load is high)
//   idx        current word index within the section
//   last       idx is the final word of the section
module loader_section_ctr #(
  parameter int MAX_LEN = 218,
  parameter int IW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [IW-1:0] load_last,
  input  logic          adv,
  output logic [IW-1:0] idx,
  output logic          last
);

  logic [IW-1:0] last_idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      last_idx_q <= '0;
    end else if (load) begin
      idx        <= '0;
      last_idx_q <= load_last;
    end else if (adv) begin
      idx <= idx + 1'b1;
    end
  end

  assign last = (idx == last_idx_q);

endmodule

// File: rtl/decap_input_loader.sv
// decap_input_loader
// Streams Classic McEliece decapsulation inputs from a 32-bit single-port
// source memory into the decap core: all s words through the s write port,
// then C1, C0 and poly_g over their valid/ready channels. Each word takes
// RD (issue read), CAP (capture read data), HOLD (present to decap; waits
// for ready on the handshaked channels). done pulses once after the last
// poly_g transfer.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   start                            one-cycle run request, honoured in IDLE
//   busy                             run in progress
//   done                             one-cycle pulse, decap may be started
//   src_rd_en/src_addr/src_dout      source memory read port (1-cycle latency)
//   s_wr_en/s_addr/s_out             decap s write port
//   C1_*, C0_*, poly_g_*             valid/ready data channels into decap
module decap_input_loader
  import mceliece_params_pkg::*;
#(
  parameter int parameter_set = 4,
  parameter int n        = set_n(parameter_set),
  parameter int m        = set_m(parameter_set),
  parameter int t        = set_t(parameter_set),
  parameter int S_WORDS  = words32(n),
  parameter int C1_WORDS = 8,
  parameter int C0_WORDS = words32(m * t),
  parameter int PG_WORDS = words32(m * (t + 1)),
  parameter int AW       = $clog2(S_WORDS + C1_WORDS + C0_WORDS + PG_WORDS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       src_rd_en,
  output logic [AW-1:0]              src_addr,
  input  logic [31:0]                src_dout,
  output logic                       s_wr_en,
  output logic [$clog2(S_WORDS)-1:0] s_addr,
  output logic [31:0]                s_out,
  output logic                       C1_valid,
  input  logic                       C1_ready,
  output logic [31:0]                C1_out,
  output logic                       C0_valid,
  input  logic                       C0_ready,
  output logic [31:0]                C0_out,
  output logic                       poly_g_valid,
  input  logic                       poly_g_ready,
  output logic [31:0]                poly_g_out
);

  localparam int SAW     = $clog2(S_WORDS);
  localparam int MAX_SC  = (S_WORDS > C1_WORDS) ? S_WORDS : C1_WORDS;
  localparam int MAX_CP  = (C0_WORDS > PG_WORDS) ? C0_WORDS : PG_WORDS;
  localparam int MAX_LEN = (MAX_SC > MAX_CP) ? MAX_SC : MAX_CP;
  localparam int IW      = $clog2(MAX_LEN);

  localparam int BASE_C1 = section_base(SEC_C1, S_WORDS, C1_WORDS, C0_WORDS);
  localparam int BASE_C0 = section_base(SEC_C0, S_WORDS, C1_WORDS, C0_WORDS);
  localparam int BASE_PG = section_base(SEC_PG, S_WORDS, C1_WORDS, C0_WORDS);

  ld_state_e     state_q, state_d;
  section_e      sec_q, sec_d;
  logic [31:0]   data_q;
  logic [IW-1:0] idx;
  logic [IW-1:0] load_last;
  logic          idx_last;
  logic          sel_ready;
  logic          accept;
  logic          xfer;
  logic          wrap;
  logic          ctr_load;
  logic          ctr_adv;
  logic [AW-1:0] base_addr;

  loader_section_ctr #(
    .MAX_LEN (MAX_LEN),
    .IW      (IW)
  ) u_ctr (
    .clk       (clk),
    .rst       (rst),
    .load      (ctr_load),
    .load_last (load_last),
    .adv       (ctr_adv),
    .idx       (idx),
    .last      (idx_last)
  );

  // ---------------------------------------------------------------------------
  // Transfer decode. Only the selected channel's ready is looked at; s has no
  // backpressure, so its HOLD cycle always completes.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    sel_ready = 1'b0;
    case (sec_q)
      SEC_C1:  sel_ready = C1_ready;
      SEC_C0:  sel_ready = C0_ready;
      SEC_PG:  sel_ready = poly_g_ready;
      default: sel_ready = 1'b0;
    endcase
  end

  assign accept   = (state_q == IDLE) && start;
  assign xfer     = (state_q == HOLD) && ((sec_q == SEC_S) || sel_ready);
  assign wrap     = xfer && idx_last;
  assign ctr_load = accept || wrap;
  assign ctr_adv  = xfer && !idx_last;

  always_comb begin
    sec_d = sec_q;
    if (accept)    sec_d = SEC_S;
    else if (wrap) sec_d = next_section(sec_q);
  end

  // Last-word index of the section being entered, latched by the counter.
  always_comb begin
    load_last = IW'(S_WORDS - 1);
    case (sec_d)
      SEC_C1:  load_last = IW'(C1_WORDS - 1);
      SEC_C0:  load_last = IW'(C0_WORDS - 1);
      SEC_PG:  load_last = IW'(PG_WORDS - 1);
      default: load_last = IW'(S_WORDS - 1);
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register, next-state logic, output decode.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before the edge, independent of statement order.
    if (rst) begin
      state_q <= IDLE;
      sec_q   <= SEC_S;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      if (state_q == CAP) data_q <= src_dout;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RD;
      RD:      state_d = CAP;
      CAP:     state_d = HOLD;
      HOLD: begin
        if (xfer) state_d = (wrap && (sec_q == SEC_PG)) ? FIN : RD;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    base_addr = '0;
    case (sec_q)
      SEC_C1:  base_addr = AW'(BASE_C1);
      SEC_C0:  base_addr = AW'(BASE_C0);
      SEC_PG:  base_addr = AW'(BASE_PG);
      default: base_addr = '0;
    endcase
  end

  always_comb begin
    busy         = (state_q != IDLE);
    done         = (state_q == FIN);
    src_rd_en    = (state_q == RD);
    s_wr_en      = (state_q == HOLD) && (sec_q == SEC_S);
    C1_valid     = (state_q == HOLD) && (sec_q == SEC_C1);
    C0_valid     = (state_q == HOLD) && (sec_q == SEC_C0);
    poly_g_valid = (state_q == HOLD) && (sec_q == SEC_PG);
  end

  // Address and data outputs come straight from registered state; the data
  // register only changes in CAP, so it is stable for the whole HOLD.
  assign src_addr   = base_addr + AW'(idx);
  assign s_addr     = SAW'(idx);
  assign s_out      = data_q;
  assign C1_out     = data_q;
  assign C0_out     = data_q;
  assign poly_g_out = data_q;

endmodule
